task_ingress_serializer: RTL and testbench

Per-lane ingress stage that sits directly upstream of the PIFO SRAM top's `i_push`/`i_pop`/`i_tree_id`/`i_push_data` ports. It accepts client push/pop requests with a valid/ready handshake. It splits a simultaneous push+pop into two ordered tasks, because the top discards a cycle in which both are asserted. It issues at most one task per lane per cycle, and only while that lane's `o_task_fifo_full` is low.

---
 rtl/task_ingress_serializer.sv | 119 +++++++++++
 tb/tb_task_ingress_serializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/task_ingress_serializer.sv
// task_ingress_serializer
// Per-lane ingress stage in front of the PIFO SRAM top. Each lane holds one
// client request and turns it into at most one push or pop task per cycle.
// A request carrying both a push and a pop is split so the push is issued
// first and the pop follows on a later cycle. Nothing is issued while the
// lane's task FIFO reports full.

module task_ingress_serializer #(
  parameter int PTW           = 16,
  parameter int MTW           = 0,
  parameter int LEVEL         = 4,
  parameter int TREE_NUM      = 4,
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM)
) (
  input  logic                          i_clk,
  input  logic                          i_arst_n,
  input  logic [LEVEL-1:0]              i_req_valid,
  input  logic [LEVEL-1:0]              i_req_push,
  input  logic [LEVEL-1:0]              i_req_pop,
  input  logic [TREE_NUM_BITS-1:0]      i_req_tree_id [0:LEVEL-1],
  input  logic [MTW+PTW-1:0]            i_req_data    [0:LEVEL-1],
  output logic [LEVEL-1:0]              o_req_ready,
  output logic [LEVEL-1:0]              o_push,
  output logic [LEVEL-1:0]              o_pop,
  output logic [TREE_NUM_BITS-1:0]      o_tree_id     [0:LEVEL-1],
  output logic [MTW+PTW-1:0]            o_push_data   [0:LEVEL-1],
  input  logic [LEVEL-1:0]              i_task_fifo_full,
  output logic [LEVEL-1:0]              o_null_req
);

  localparam int DW = MTW + PTW;

  // EMPTY: nothing held. SINGLE: one push or one pop held.
  // PAIR: a push held with a pop queued behind it.
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    SINGLE = 2'd1,
    PAIR   = 2'd2
  } lane_state_t;

  for (genvar l = 0; l < LEVEL; l++) begin : g_lane

    lane_state_t              state_q;
    lane_state_t              state_d;
    logic                     held_pop_q;
    logic                     held_pop_d;
    logic [TREE_NUM_BITS-1:0] tree_q;
    logic [DW-1:0]            data_q;
    logic                     issue;
    logic                     accept;
    logic                     single_push;
    logic                     single_pop;

    // A held task goes out whenever the downstream FIFO has room. A new
    // request can only be taken when the slot is empty or its single task
    // leaves this very cycle; ready is forced low while reset is asserted.
    assign issue       = (state_q != EMPTY) && !i_task_fifo_full[l];
    assign single_push = (state_q == SINGLE) && !held_pop_q;
    assign single_pop  = (state_q == SINGLE) &&  held_pop_q;

    assign o_req_ready[l] = i_arst_n &&
                            ((state_q == EMPTY) || ((state_q == SINGLE) && issue));
    assign accept         = i_req_valid[l] && o_req_ready[l];
    assign o_null_req[l]  = accept && !i_req_push[l] && !i_req_pop[l];

    // In PAIR the push always goes first, so push and pop never coincide.
    assign o_push[l]      = issue && ((state_q == PAIR) || single_push);
    assign o_pop[l]       = issue && single_pop;
    assign o_push_data[l] = o_push[l] ? data_q : '0;
    assign o_tree_id[l]   = (state_q != EMPTY) ? tree_q : '0;

    // Next-state: a new accept overrides the slot; otherwise an issued task
    // either leaves a queued pop behind (PAIR) or empties the slot.
    always_comb begin
      state_d    = state_q;
      held_pop_d = held_pop_q;
      if (accept) begin
        if (i_req_push[l] && i_req_pop[l]) begin
          state_d    = PAIR;
          held_pop_d = 1'b0;
        end else if (i_req_push[l] || i_req_pop[l]) begin
          state_d    = SINGLE;
          held_pop_d = i_req_pop[l];
        end else begin
          state_d    = EMPTY;
          held_pop_d = 1'b0;
        end
      end else if (issue) begin
        if (state_q == PAIR) begin
          state_d    = SINGLE;
          held_pop_d = 1'b1;
        end else begin
          state_d    = EMPTY;
          held_pop_d = 1'b0;
        end
      end
    end

    // Slot registers: state advances every cycle, payload only on accept so
    // the queued pop reuses the tree id of its original request.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
        state_q    <= EMPTY;
        held_pop_q <= 1'b0;
        tree_q     <= '0;
        data_q     <= '0;
      end else begin
        state_q    <= state_d;
        held_pop_q <= held_pop_d;
        if (accept) begin
          tree_q <= i_req_tree_id[l];
          data_q <= i_req_data[l];
        end
      end
    end

  end : g_lane

endmodule

// File: tb/tb_task_ingress_serializer.sv
// Bench for task_ingress_serializer: directed scenarios plus random traffic,
// all checked against a per-lane task queue model.

module tb_task_ingress_serializer;

  localparam int PTW   = 16;
  localparam int MTW   = 0;
  localparam int DW    = MTW + PTW;
  localparam int LEVEL = 4;
  localparam int TREE_NUM = 4;
  localparam int TW    = $clog2(TREE_NUM);

  logic              clk;
  logic              rst_n;
  logic [LEVEL-1:0]  req_valid;
  logic [LEVEL-1:0]  req_push;
  logic [LEVEL-1:0]  req_pop;
  logic [TW-1:0]     req_tree [0:LEVEL-1];
  logic [DW-1:0]     req_data [0:LEVEL-1];
  logic [LEVEL-1:0]  req_ready;
  logic [LEVEL-1:0]  push;
  logic [LEVEL-1:0]  pop;
  logic [TW-1:0]     tree_id  [0:LEVEL-1];
  logic [DW-1:0]     push_data[0:LEVEL-1];
  logic [LEVEL-1:0]  fifo_full;
  logic [LEVEL-1:0]  null_req;

  int vectors;
  int miscompares;

  // One pending downstream task as the client would describe it.
  typedef struct packed {
    logic          is_pop;
    logic [TW-1:0] tree;
    logic [DW-1:0] data;
  } task_t;

  task_t model_q [LEVEL][$];

  task_ingress_serializer #(
    .PTW(PTW), .MTW(MTW), .LEVEL(LEVEL), .TREE_NUM(TREE_NUM), .TREE_NUM_BITS(TW)
  ) dut (
    .i_clk           (clk),
    .i_arst_n        (rst_n),
    .i_req_valid     (req_valid),
    .i_req_push      (req_push),
    .i_req_pop       (req_pop),
    .i_req_tree_id   (req_tree),
    .i_req_data      (req_data),
    .o_req_ready     (req_ready),
    .o_push          (push),
    .o_pop           (pop),
    .o_tree_id       (tree_id),
    .o_push_data     (push_data),
    .i_task_fifo_full(fifo_full),
    .o_null_req      (null_req)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check every lane against the queue model, advance the model to the
  // coming edge, then move to the next falling edge where inputs change.
  task automatic applyStimulus();
    #1;
    if (!rst_n)
      for (int l = 0; l < LEVEL; l++) model_q[l].delete();
    for (int l = 0; l < LEVEL; l++) begin
      automatic int    depth  = model_q[l].size();
      automatic bit    has    = depth > 0;
      automatic bit    iss    = has && !fifo_full[l];
      automatic task_t head   = has ? model_q[l][0] : '0;
      automatic bit    e_rdy  = rst_n && (depth == 0 || (depth == 1 && !fifo_full[l]));
      automatic bit    e_push = iss && !head.is_pop;
      automatic bit    e_pop  = iss && head.is_pop;
      automatic bit    acc    = req_valid[l] && e_rdy;
      automatic bit    e_null = acc && !req_push[l] && !req_pop[l];
      checkOutput($sformatf("ready[%0d]", l), 32'(req_ready[l]), 32'(e_rdy));
      checkOutput($sformatf("push[%0d]", l), 32'(push[l]), 32'(e_push));
      checkOutput($sformatf("pop[%0d]", l), 32'(pop[l]), 32'(e_pop));
      checkOutput($sformatf("tree[%0d]", l), 32'(tree_id[l]), has ? 32'(head.tree) : 32'd0);
      checkOutput($sformatf("data[%0d]", l), 32'(push_data[l]), e_push ? 32'(head.data) : 32'd0);
      checkOutput($sformatf("null[%0d]", l), 32'(null_req[l]), 32'(e_null));
      checkOutput($sformatf("excl[%0d]", l), 32'(push[l] & pop[l]), 32'd0);
      if (rst_n) begin
        if (iss) void'(model_q[l].pop_front());
        if (acc && req_push[l]) model_q[l].push_back({1'b0, req_tree[l], req_data[l]});
        if (acc && req_pop[l])  model_q[l].push_back({1'b1, req_tree[l], {DW{1'b0}}});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic setReq(input int l, input bit v, input bit pu, input bit po,
                        input logic [TW-1:0] t, input logic [DW-1:0] d);
    req_valid[l] = v;
    req_push[l]  = pu;
    req_pop[l]   = po;
    req_tree[l]  = t;
    req_data[l]  = d;
  endtask

  task automatic idleAll();
    for (int l = 0; l < LEVEL; l++) setReq(l, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clk         = 1'b0;
    rst_n       = 1'b0;
    fifo_full   = '0;
    for (int l = 0; l < LEVEL; l++) setReq(l, 1'b1, 1'b1, 1'b0, 2'd1, 16'h1234);
    @(negedge clk);

    // Reset held with valid requests: everything quiet, ready low
    applyStimulus();
    applyStimulus();
    rst_n = 1'b1;
    idleAll();
    applyStimulus();
    applyStimulus();

    // Four back-to-back pushes on lane 0
    for (int i = 0; i < 4; i++) begin
      setReq(0, 1'b1, 1'b1, 1'b0, 2'd1, 16'h0011 + 16'(i));
      applyStimulus();
    end
    idleAll();
    applyStimulus();
    applyStimulus();

    // Push+pop on lane 2 splits into push then pop
    setReq(2, 1'b1, 1'b1, 1'b1, 2'd3, 16'hBEEF);
    applyStimulus();
    idleAll();
    repeat (3) applyStimulus();

    // Backpressure on lane 1, then release with a new request the same cycle
    setReq(1, 1'b1, 1'b1, 1'b0, 2'd2, 16'hA5A5);
    fifo_full[1] = 1'b1;
    applyStimulus();
    idleAll();
    setReq(1, 1'b1, 1'b1, 1'b0, 2'd0, 16'h5A5A);
    repeat (5) applyStimulus();
    fifo_full[1] = 1'b0;
    applyStimulus();
    idleAll();
    repeat (2) applyStimulus();

    // Null request
    setReq(0, 1'b1, 1'b0, 1'b0, 2'd2, 16'h7777);
    applyStimulus();
    idleAll();
    applyStimulus();

    // Lane 3 stuck full with a pair held while lanes 0-2 stream
    fifo_full[3] = 1'b1;
    setReq(3, 1'b1, 1'b1, 1'b1, 2'd2, 16'hC0DE);
    for (int i = 0; i < 8; i++) begin
      for (int l = 0; l < 3; l++)
        setReq(l, 1'b1, 1'b1, 1'b0, TW'($urandom_range(0, TREE_NUM - 1)), DW'($urandom));
      applyStimulus();
      req_valid[3] = 1'b0;
    end
    fifo_full[3] = 1'b0;
    idleAll();
    repeat (3) applyStimulus();

    // Reset while lane 0 is holding the pop of a pair
    setReq(0, 1'b1, 1'b1, 1'b1, 2'd1, 16'h1357);
    applyStimulus();
    idleAll();
    applyStimulus();
    rst_n = 1'b0;
    applyStimulus();
    rst_n = 1'b1;
    repeat (3) applyStimulus();

    // Random traffic with random backpressure
    for (int c = 0; c < 600; c++) begin
      for (int l = 0; l < LEVEL; l++) begin
        setReq(l, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), TW'($urandom_range(0, TREE_NUM - 1)), DW'($urandom));
        fifo_full[l] = ($urandom_range(0, 3) == 0);
      end
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
